// File: rtl/sim_exit_monitor_if.sv
// Observation bus from the core to the end-of-test monitor: decode-stage
// instruction, data-memory write port and the current gp (x3) value.
interface sim_exit_monitor_if #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 32
);
  logic              inst_valid;
  logic [XLEN-1:0]   inst;
  logic [AWIDTH-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [2:0]        mem_we;
  logic [XLEN-1:0]   gp_value;

  // Core (or bench) side drives the observed signals.
  modport master (
    output inst_valid, inst, mem_addr, mem_wdata, mem_we, gp_value
  );

  // Monitor side only watches.
  modport slave (
    input  inst_valid, inst, mem_addr, mem_wdata, mem_we, gp_value
  );
endinterface

// File: rtl/sim_exit_monitor.sv
// End-of-test monitor: detects ECALL / EBREAK / tohost store / cycle timeout,
// optionally waits for the pipeline to drain before sampling gp, then latches
// a sticky pass/fail verdict, exit cause, result word and run counters.
module sim_exit_monitor #(
  parameter int          XLEN           = 32,
  parameter int          AWIDTH         = 32,
  parameter int          CNT_WIDTH      = 32,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter int          DRAIN_CYCLES   = 4,
  parameter bit          TOHOST_EN      = 1'b1,
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter bit          EBREAK_EN      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  sim_exit_monitor_if.slave    core,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [1:0]           exit_cause,
  output logic [XLEN-1:0]      result,
  output logic [XLEN-1:0]      fail_id,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] inst_count
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_ECALL  = 2'b01;
  localparam logic [1:0] CAUSE_EBREAK = 2'b10;
  localparam logic [1:0] CAUSE_TOHOST = 2'b11;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [XLEN-1:0]   result_d;
  logic [1:0]        cause_d;
  logic              timeout_d;
  logic              finish;
  logic              pass_d;

  logic hit_ecall, hit_ebreak, hit_tohost, hit_timeout, count_en;

  assign hit_ecall   = core.inst_valid && (core.inst == XLEN'(32'h0000_0073));
  assign hit_ebreak  = EBREAK_EN && core.inst_valid && (core.inst == XLEN'(32'h0010_0073));
  assign hit_tohost  = TOHOST_EN && (core.mem_we != 3'b000) &&
                       (core.mem_addr == AWIDTH'(TOHOST_ADDR));
  assign hit_timeout = (TIMEOUT_CYCLES != 0) && run &&
                       (cycle_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  // Counters run in RUN and DRAIN only; DONE freezes them.
  assign count_en = run && (state_q != S_DONE);

  assign fail_id = result >> 1;

  // State register and drain counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order races.
    if (rst) begin
      state_q <= S_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic with trigger priority tohost > ECALL > EBREAK > timeout.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    drain_d   = drain_q;
    result_d  = result;
    cause_d   = exit_cause;
    timeout_d = timeout;
    finish    = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (hit_tohost) begin
          result_d = core.mem_wdata;
          cause_d  = CAUSE_TOHOST;
          state_d  = S_DONE;
          finish   = 1'b1;
        end else if (hit_ecall || hit_ebreak) begin
          cause_d = hit_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
          if (DRAIN_CYCLES == 0) begin
            result_d = core.gp_value;
            state_d  = S_DONE;
            finish   = 1'b1;
          end else begin
            drain_d = DW'(DRAIN_CYCLES);
            state_d = S_DRAIN;
          end
        end else if (hit_timeout) begin
          result_d  = '1;
          timeout_d = 1'b1;
          cause_d   = CAUSE_NONE;
          state_d   = S_DONE;
          finish    = 1'b1;
        end
      end
      S_DRAIN: begin
        // Drain ticks every cycle, independent of run; new triggers ignored.
        drain_d = drain_q - 1'b1;
        if (drain_q == DW'(1)) begin
          result_d = core.gp_value;
          state_d  = S_DONE;
          finish   = 1'b1;
        end
      end
      default: ;
    endcase
    pass_d = (result_d == XLEN'(1)) && !timeout_d;
  end

  // Latched verdict, exit record and saturating run counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      exit_cause  <= CAUSE_NONE;
      result      <= '0;
      cycle_count <= '0;
      inst_count  <= '0;
    end else begin
      result     <= result_d;
      exit_cause <= cause_d;
      timeout    <= timeout_d;
      if (finish) begin
        done <= 1'b1;
        pass <= pass_d;
        fail <= !pass_d;
      end
      if (count_en && (cycle_count != '1)) begin
        cycle_count <= cycle_count + 1'b1;
      end
      if (count_en && core.inst_valid && (inst_count != '1)) begin
        inst_count <= inst_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sim_exit_monitor.sv
// Directed bench for sim_exit_monitor. Two instances share one observation
// bus: dut_a (drain 4, EBREAK on) and dut_b (drain 0, EBREAK off).
module tb_sim_exit_monitor;
  localparam int          XLEN   = 32;
  localparam int          AWIDTH = 32;
  localparam int          CW     = 32;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] TOHOST = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  sim_exit_monitor_if #(.XLEN(XLEN), .AWIDTH(AWIDTH)) core_bus ();

  logic            a_done, a_pass, a_fail, a_timeout;
  logic [1:0]      a_exit_cause;
  logic [XLEN-1:0] a_result, a_fail_id;
  logic [CW-1:0]   a_cycle_count, a_inst_count;
  logic            b_done, b_pass, b_fail, b_timeout;
  logic [1:0]      b_exit_cause;
  logic [XLEN-1:0] b_result, b_fail_id;
  logic [CW-1:0]   b_cycle_count, b_inst_count;

  always #5 clk = ~clk;

  sim_exit_monitor #(
    .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(4), .EBREAK_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .run(run), .core(core_bus.slave),
    .done(a_done), .pass(a_pass), .fail(a_fail), .timeout(a_timeout),
    .exit_cause(a_exit_cause), .result(a_result), .fail_id(a_fail_id),
    .cycle_count(a_cycle_count), .inst_count(a_inst_count)
  );

  sim_exit_monitor #(
    .TIMEOUT_CYCLES(100), .DRAIN_CYCLES(0), .EBREAK_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .run(run), .core(core_bus.slave),
    .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
    .exit_cause(b_exit_cause), .result(b_result), .fail_id(b_fail_id),
    .cycle_count(b_cycle_count), .inst_count(b_inst_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, then land #1 after the closing edge.
  task automatic drive(input logic valid, input logic [31:0] instr, input logic [2:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] gp);
    core_bus.inst_valid = valid;
    core_bus.inst       = instr;
    core_bus.mem_we     = we;
    core_bus.mem_addr   = addr;
    core_bus.mem_wdata  = wdata;
    core_bus.gp_value   = gp;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic valid, input logic [31:0] instr, input logic [31:0] gp);
    drive(valid, instr, 3'b000, 32'h0, 32'h0, gp);
  endtask

  // Leaves the bench in cycle 0 with rst low.
  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, NOP, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    run = 1'b1;
    do_reset();
    check("reset_done", a_done, 0);
    check("reset_pass_fail", {a_pass, a_fail}, 0);
    check("reset_result", a_result, 0);

    // ECALL at cycle 20 with gp=1; dut_a drains 4, dut_b finishes at once.
    for (int c = 0; c < 25; c++) begin
      cyc(1'b1, (c == 20) ? ECALL : NOP, 32'h1);
      if (c == 20) begin
        check("d0_done", b_done, 1);
        check("d0_pass", b_pass, 1);
        check("d0_result", b_result, 1);
        check("d0_inst_count", b_inst_count, 21);
      end
      if (c == 23) check("drain_not_done", a_done, 0);
    end
    check("ecall_done", a_done, 1);
    check("ecall_pass", {a_pass, a_fail}, 2'b10);
    check("ecall_cause", a_exit_cause, 1);
    check("ecall_result", a_result, 1);
    check("ecall_inst_count", a_inst_count, 25);
    check("ecall_cycle_count", a_cycle_count, 25);
    // DONE is frozen against later triggers.
    drive(1'b1, ECALL, 3'b111, TOHOST, 32'h5, 32'h0);
    cyc(1'b1, NOP, 32'h0);
    check("frozen_result", a_result, 1);
    check("frozen_cause", a_exit_cause, 1);
    check("frozen_cycles", a_cycle_count, 25);

    // gp goes 7 -> 1 during the drain window.
    do_reset();
    for (int c = 0; c < 25; c++) cyc(1'b1, (c == 20) ? ECALL : NOP, (c >= 23) ? 32'h1 : 32'h7);
    check("gp_late_result", a_result, 1);
    check("gp_late_pass", a_pass, 1);
    check("d0_gp7_fail", b_fail, 1);
    check("d0_gp7_fail_id", b_fail_id, 3);

    // gp stays 7: failing test number 3.
    do_reset();
    for (int c = 0; c < 25; c++) cyc(1'b1, (c == 20) ? ECALL : NOP, 32'h7);
    check("gp7_fail", {a_pass, a_fail}, 2'b01);
    check("gp7_result", a_result, 7);
    check("gp7_fail_id", a_fail_id, 3);

    // tohost store wins over a same-cycle ECALL.
    do_reset();
    for (int c = 0; c < 5; c++) cyc(1'b1, NOP, 32'h1);
    check("tohost_pre", a_done, 0);
    drive(1'b1, ECALL, 3'b001, TOHOST, 32'h0000_000B, 32'h1);
    check("tohost_done", a_done, 1);
    check("tohost_cause", a_exit_cause, 3);
    check("tohost_result", a_result, 32'hB);
    check("tohost_fail", {a_pass, a_fail}, 2'b01);
    check("tohost_fail_id", a_fail_id, 5);
    check("tohost_cause_b", b_exit_cause, 3);

    // Timeout after 100 run cycles.
    do_reset();
    for (int c = 0; c < 100; c++) begin
      cyc(1'b0, NOP, 32'h1);
      if (c == 98) check("to_pre", a_done, 0);
    end
    check("to_done", a_done, 1);
    check("to_flag", a_timeout, 1);
    check("to_fail", {a_pass, a_fail}, 2'b01);
    check("to_result", a_result, 32'hFFFF_FFFF);
    check("to_cause", a_exit_cause, 0);
    check("to_cycles", a_cycle_count, 100);

    // run=0 for 10 cycles pushes the timeout out by 10.
    do_reset();
    for (int c = 0; c < 110; c++) begin
      run = !(c >= 10 && c < 20);
      cyc(1'b0, NOP, 32'h1);
      if (c == 108) check("to_hold_pre", a_done, 0);
    end
    run = 1'b1;
    check("to_hold_done", a_done, 1);
    check("to_hold_cycles", a_cycle_count, 100);

    // Reset during DRAIN.
    do_reset();
    for (int c = 0; c < 22; c++) cyc(1'b1, (c == 20) ? ECALL : NOP, 32'h1);
    rst = 1'b1;
    cyc(1'b1, NOP, 32'h1);
    rst = 1'b0;
    check("rst_drain_outs", {a_done, a_pass, a_fail, a_timeout, a_exit_cause}, 0);
    check("rst_drain_counts", {a_cycle_count, a_inst_count}, 0);
    check("rst_drain_b", {b_done, b_pass, b_fail}, 0);
    for (int c = 0; c < 6; c++) cyc(1'b1, NOP, 32'h1);
    check("rst_drain_stays", a_done, 0);
    drive(1'b1, NOP, 3'b010, TOHOST, 32'h1, 32'h0);
    check("rst_tohost_pass", {a_done, a_pass, a_fail}, 3'b110);
    // Reset in DONE.
    rst = 1'b1;
    cyc(1'b1, NOP, 32'h1);
    rst = 1'b0;
    check("rst_done_outs", {a_done, a_pass, a_fail, a_exit_cause}, 0);
    check("rst_done_result", a_result, 0);
    check("rst_done_cycles", a_cycle_count, 0);
    for (int c = 0; c < 15; c++) cyc(1'b1, (c == 10) ? EBREAK : NOP, 32'h1);
    check("ebreak_done", a_done, 1);
    check("ebreak_cause", a_exit_cause, 2);
    check("ebreak_pass", {a_pass, a_fail}, 2'b10);
    check("ebreak_inst_count", a_inst_count, 15);
    check("ebreak_off_b", b_done, 0);
    check("ebreak_off_b_count", b_inst_count, 15);

    // EBREAK disabled, tohost address without a write, ECALL without valid.
    do_reset();
    for (int c = 0; c < 5; c++) cyc(1'b1, NOP, 32'h1);
    drive(1'b1, EBREAK, 3'b000, TOHOST, 32'h1, 32'h1);
    cyc(1'b0, ECALL, 32'h1);
    for (int c = 0; c < 4; c++) cyc(1'b1, NOP, 32'h1);
    check("notrig_b_done", b_done, 0);
    check("notrig_b_cycles", b_cycle_count, 11);
    check("notrig_b_inst", b_inst_count, 10);
    check("notrig_a_cause", a_exit_cause, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sim_exit_monitor.md
Name: sim_exit_monitor

Overview:
- Synthesizable end-of-test monitor for the top_core simulation and FPGA harness. It replaces ad-hoc ECALL/timeout checks inside benches.
- Watches the decode-stage instruction stream, data-memory writes and the gp (x3) register value.
- Detects test exit by ECALL, EBREAK or a tohost store, or by a cycle timeout. Latches a pass/fail verdict, exit cause, result word and cycle/instruction counters.
- Sits beside top_core; its outputs drive bench $finish logic or board LEDs.

Parameters:
XLEN, 32, data/instruction width
AWIDTH, 32, data-memory address width
CNT_WIDTH, 32, width of cycle and instruction counters
TIMEOUT_CYCLES, 5000, run cycles before timeout; 0 disables timeout
DRAIN_CYCLES, 4, cycles waited after ECALL/EBREAK before sampling gp; 0 samples in the trigger cycle
TOHOST_EN, 1, enable tohost store detection
TOHOST_ADDR, 32'h0000_1000, tohost word address
EBREAK_EN, 1, enable EBREAK detection

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
run  in  1  count enable; 0 holds counters and the timeout
inst_valid  in  1  inst holds a real decoded instruction this cycle
inst  in  XLEN  decode-stage instruction word
mem_addr  in  AWIDTH  data-memory address
mem_wdata  in  XLEN  data-memory write data
mem_we  in  3  data-memory write enable; any nonzero value is a write
gp_value  in  XLEN  current x3 contents
done  out  1  test finished (sticky)
pass  out  1  verdict pass (sticky)
fail  out  1  verdict fail (sticky)
timeout  out  1  finished by timeout
exit_cause  out  2  00 none/timeout, 01 ECALL, 10 EBREAK, 11 tohost
result  out  XLEN  latched exit word
fail_id  out  XLEN  result >> 1 (failing test number)
cycle_count  out  CNT_WIDTH  cycles spent in RUN/DRAIN with run=1
inst_count  out  CNT_WIDTH  valid instructions seen in RUN/DRAIN

Behaviour:
- Reset: all outputs 0; state RUN; drain counter 0. Reset applies at the next clk edge from any state, including DRAIN and DONE.
- Triggers (inst_valid=1 is required for instruction triggers):
  - ECALL: inst==32'h0000_0073.
  - EBREAK: inst==32'h0010_0073 and EBREAK_EN=1.
  - tohost: mem_we!=0, mem_addr==TOHOST_ADDR and TOHOST_EN=1.
  - Same-cycle priority: tohost > ECALL > EBREAK > timeout.
- States RUN, DRAIN, DONE.
- RUN:
  - When run=1, cycle_count increments; inst_count increments on inst_valid. Both saturate at all-ones.
  - tohost trigger: result<=mem_wdata, exit_cause<=11, go to DONE.
  - ECALL/EBREAK trigger:
    - exit_cause<=01/10.
    - DRAIN_CYCLES>0: load drain counter with DRAIN_CYCLES, go to DRAIN.
    - DRAIN_CYCLES=0: result<=gp_value, go to DONE.
  - Timeout: TIMEOUT_CYCLES!=0, run=1, no trigger, and cycle_count==TIMEOUT_CYCLES-1. Then result<=all-ones, timeout<=1, exit_cause<=00, go to DONE.
- DRAIN:
  - The counter decrements every cycle regardless of run.
  - The cycle where the counter is 1: result<=gp_value, go to DONE.
  - Counters keep counting per RUN rules. New triggers and the timeout are ignored.
- Verdict is set on entry to DONE:
  - done<=1.
  - pass<=(result==1 and not timeout).
  - fail<=!pass.
  - fail_id is combinational from result.
- DONE: all outputs frozen until rst; further triggers ignored.
- Latency:
  - tohost store in cycle N: done=1 in cycle N+1.
  - ECALL in cycle N with D=DRAIN_CYCLES: gp sampled at the end of cycle N+D, done=1 in cycle N+D+1.
- Exactly one of pass/fail is 1 whenever done=1; both are 0 while done=0.

Test Plan:
- gp_value=1, ECALL at cycle 20, DRAIN_CYCLES=4 -> done rises cycle 25; pass=1, exit_cause=01, result=1, inst_count = valid instructions through cycle 24.
- gp_value changes 7->1 during drain (1 at cycle 23), ECALL at cycle 20 -> result=1, pass=1. Repeat with gp left at 7 -> fail=1, fail_id=3.
- Store 32'h0000_000B to TOHOST_ADDR in the same cycle as ECALL -> exit_cause=11, result=0xB, fail=1, fail_id=5, done next cycle.
- No trigger, TIMEOUT_CYCLES=100, run=1 -> done at cycle_count=100; timeout=1, fail=1, result=32'hFFFF_FFFF. Hold run=0 for 10 cycles -> timeout delayed by 10 cycles.
- Pulse rst during DRAIN and again in DONE -> all outputs 0 the next cycle; a subsequent EBREAK with gp=1 gives exit_cause=10 and pass=1.
- EBREAK_EN=0 and EBREAK issued; mem_we=0 at TOHOST_ADDR -> no trigger, counters keep running.
